seg_disp_arbiter: RTL



---
 rtl/seg_disp_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/seg_disp_arbiter.sv
// Round-robin time-share of the 6-digit seven-segment driver between three requesters,
// with a programmable dwell per page and a blank gap between pages.
module seg_disp_arbiter #(
  parameter logic [15:0] CNT_1MS_MAX = 16'd49_999,
  parameter logic [15:0] DWELL_MS    = 16'd2000,
  parameter logic [7:0]  BLANK_MS    = 8'd20
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [2:0]  req,
  input  logic [19:0] data0,
  input  logic [19:0] data1,
  input  logic [19:0] data2,
  input  logic [5:0]  point0,
  input  logic [5:0]  point1,
  input  logic [5:0]  point2,
  input  logic        sign0,
  input  logic        sign1,
  input  logic        sign2,
  input  logic        lock,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        sign,
  output logic        seg_en,
  output logic [2:0]  grant,
  output logic        switch_pulse
);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_1ms_q, cnt_1ms_d;
  logic [15:0] cnt_dwell_q, cnt_dwell_d;
  logic [7:0]  cnt_blank_q, cnt_blank_d;
  logic [1:0]  last_ptr_q, last_ptr_d;
  logic [2:0]  grant_q, grant_d;
  logic        switch_pulse_q, switch_pulse_d;
  logic [19:0] data_q, data_d;
  logic [5:0]  point_q, point_d;
  logic        sign_q, sign_d;
  logic        seg_en_q, seg_en_d;

  logic        tick;
  logic        pick_found;
  logic [1:0]  pick_idx;
  logic [2:0]  pick_oh;

  assign tick = (cnt_1ms_q == CNT_1MS_MAX);

  // Search last_ptr+1, +2, then last_ptr itself; first hit wins.
  always_comb begin
    logic [2:0] sum;
    logic [1:0] idx;
    pick_found = 1'b0;
    pick_idx   = last_ptr_q;
    for (int unsigned k = 1; k <= 3; k++) begin
      sum = {1'b0, last_ptr_q} + 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
    pick_oh = 3'b001 << pick_idx;
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_ptr_d     = last_ptr_q;
    cnt_1ms_d      = tick ? '0 : cnt_1ms_q + 16'd1;
    cnt_dwell_d    = cnt_dwell_q;
    cnt_blank_d    = cnt_blank_q;
    switch_pulse_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_found) begin
          state_d        = SHOW;
          grant_d        = pick_oh;
          last_ptr_d     = pick_idx;
          switch_pulse_d = 1'b1;
        end
      end
      SHOW: begin
        if ((req & grant_q) == '0) begin
          state_d = BLANK;
          grant_d = '0;
        end else if (lock) begin
          cnt_dwell_d = cnt_dwell_q;
        end else if (tick) begin
          if (cnt_dwell_q == DWELL_MS - 16'd1) begin
            if ((req & ~grant_q) != '0) begin
              state_d = BLANK;
              grant_d = '0;
            end else begin
              cnt_dwell_d = '0;
            end
          end else begin
            cnt_dwell_d = cnt_dwell_q + 16'd1;
          end
        end
      end
      BLANK: begin
        grant_d = '0;
        if (tick) begin
          if (cnt_blank_q == BLANK_MS - 8'd1) begin
            if (pick_found) begin
              state_d        = SHOW;
              grant_d        = pick_oh;
              last_ptr_d     = pick_idx;
              switch_pulse_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_blank_d = cnt_blank_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    // Every state change restarts all timing so page and blank lengths are exact.
    if (state_d != state_q) begin
      cnt_1ms_d   = '0;
      cnt_dwell_d = '0;
      cnt_blank_d = '0;
    end
  end

  always_comb begin
    data_d   = '0;
    point_d  = '0;
    sign_d   = 1'b0;
    seg_en_d = 1'b0;
    if (state_q == SHOW) begin
      seg_en_d = 1'b1;
      if (grant_q[0]) begin
        data_d = data0; point_d = point0; sign_d = sign0;
      end else if (grant_q[1]) begin
        data_d = data1; point_d = point1; sign_d = sign1;
      end else if (grant_q[2]) begin
        data_d = data2; point_d = point2; sign_d = sign2;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= IDLE;
      cnt_1ms_q      <= '0;
      cnt_dwell_q    <= '0;
      cnt_blank_q    <= '0;
      last_ptr_q     <= 2'd2;
      grant_q        <= '0;
      switch_pulse_q <= 1'b0;
      data_q         <= '0;
      point_q        <= '0;
      sign_q         <= 1'b0;
      seg_en_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_1ms_q      <= cnt_1ms_d;
      cnt_dwell_q    <= cnt_dwell_d;
      cnt_blank_q    <= cnt_blank_d;
      last_ptr_q     <= last_ptr_d;
      grant_q        <= grant_d;
      switch_pulse_q <= switch_pulse_d;
      data_q         <= data_d;
      point_q        <= point_d;
      sign_q         <= sign_d;
      seg_en_q       <= seg_en_d;
    end
  end

  assign data         = data_q;
  assign point        = point_q;
  assign sign         = sign_q;
  assign seg_en       = seg_en_q;
  assign grant        = grant_q;
  assign switch_pulse = switch_pulse_q;

endmodule
